// File: rtl/mem_arbiter.sv
// Byte-serial RAM controller arbitrating NUM_CH requesters onto one 8-bit RAM port.
// Define MEMARB_RR_EN for round-robin arbitration; default is fixed priority (channel 0 highest).
module mem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_CH-1:0]        req_in,
  input  logic [NUM_CH-1:0]        rw_in,
  input  logic [NUM_CH*ADDR_W-1:0] addr_in,
  input  logic [NUM_CH*32-1:0]     wdata_in,
  input  logic [NUM_CH*3-1:0]      len_in,
  input  logic [NUM_CH-1:0]        flush_in,
  output logic [NUM_CH-1:0]        busy_out,
  output logic [NUM_CH-1:0]        done_out,
  output logic [31:0]              rdata_out,
  output logic                     ram_rw_out,
  output logic [ADDR_W-1:0]        ram_addr_out,
  output logic [7:0]               ram_data_out,
  input  logic [7:0]               ram_data_in
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  function automatic logic [2:0] decode_len(input logic [2:0] l);
    case (l)
      3'd1:    decode_len = 3'd1;
      3'd2:    decode_len = 3'd2;
      default: decode_len = 3'd4;
    endcase
  endfunction

`ifdef MEMARB_RR_EN
  function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    rr_index = (s >= NUM_CH) ? CH_W'(s - NUM_CH) : CH_W'(s);
  endfunction

  logic [CH_W-1:0]   r_ptr;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_ch;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [2:0]          r_len;
  logic [2:0]          r_cnt;
  logic [23:0]         r_bytes;
  logic [NUM_CH-1:0]   r_busy;
  logic [NUM_CH-1:0]   r_done;
  logic [31:0]         r_rdata;

  logic [NUM_CH-1:0]   w_elig;
  logic                w_any;
  logic [CH_W-1:0]     w_sel;
  logic [NUM_CH-1:0]   w_sel_oh;
  logic                w_grant;
  logic                w_finish;
  logic                w_abort;
  logic [2:0]          w_end_cnt;
  logic [2:0]          w_off;
  logic [31:0]         w_assembled;
  logic                w_xfer;

  // A channel that just saw its done pulse is masked so it cannot be re-granted.
  assign w_elig   = req_in & ~flush_in & ~r_done;
  assign w_any    = |w_elig;
  assign w_sel_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << w_sel;

  // Channel selection: last assignment in the descending scan wins.
  always_comb begin
    w_sel = '0;
`ifdef MEMARB_RR_EN
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_sel = w_elig[rr_index(r_ptr, k)] ? rr_index(r_ptr, k) : w_sel;
    end
`else
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_sel = w_elig[i] ? CH_W'(i) : w_sel;
    end
`endif
  end

  assign w_end_cnt = r_rw ? (r_len - 3'd1) : r_len;

  // Next-state logic and transfer control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = XFER;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      XFER: begin
        if (!r_rw && flush_in[r_ch]) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == w_end_cnt) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = XFER;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Final read byte arrives on ram_data_in in the same cycle the result is latched.
  always_comb begin
    case (r_len)
      3'd1:    w_assembled = {24'h000000, ram_data_in};
      3'd2:    w_assembled = {16'h0000, ram_data_in, r_bytes[7:0]};
      default: w_assembled = {ram_data_in, r_bytes};
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch, byte counter, read capture and handshake registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ch    <= '0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h00000000;
      r_len   <= 3'd0;
      r_cnt   <= 3'd0;
      r_bytes <= 24'h000000;
      r_busy  <= '0;
      r_done  <= '0;
      r_rdata <= 32'h00000000;
`ifdef MEMARB_RR_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_done <= '0;
      if (w_grant) begin
        r_ch    <= w_sel;
        r_rw    <= rw_in[w_sel];
        r_addr  <= addr_in[w_sel*ADDR_W +: ADDR_W];
        r_wdata <= wdata_in[w_sel*32 +: 32];
        r_len   <= decode_len(len_in[w_sel*3 +: 3]);
        r_cnt   <= 3'd0;
        r_busy  <= w_sel_oh;
`ifdef MEMARB_RR_EN
        r_ptr   <= (w_sel == CH_W'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;
`endif
      end else if (w_abort) begin
        r_busy <= '0;
      end else if (w_finish) begin
        r_busy <= '0;
        r_done <= r_busy;
        if (!r_rw) begin
          r_rdata <= w_assembled;
        end
      end else if (r_state == XFER) begin
        r_cnt <= r_cnt + 3'd1;
        if (!r_rw) begin
          case (r_cnt)
            3'd1:    r_bytes[7:0]   <= ram_data_in;
            3'd2:    r_bytes[15:8]  <= ram_data_in;
            3'd3:    r_bytes[23:16] <= ram_data_in;
            default: r_bytes        <= r_bytes;
          endcase
        end
      end
    end
  end

  // During the trailing read cycle the address stays on the last byte.
  assign w_xfer = (r_state == XFER);
  assign w_off  = (!r_rw && (r_cnt == r_len)) ? (r_cnt - 3'd1) : r_cnt;

  assign busy_out     = r_busy;
  assign done_out     = r_done;
  assign rdata_out    = r_rdata;
  assign ram_rw_out   = w_xfer & r_rw;
  assign ram_addr_out = w_xfer ? (r_addr + ADDR_W'(w_off)) : '0;
  assign ram_data_out = (w_xfer && r_rw) ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (32-bit and 8-bit address instances).
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, rw, flush;
  logic [63:0] addr, wdata;
  logic [5:0]  len;
  logic [1:0]  busy, done;
  logic [31:0] rdata;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wd, ram_rd;

  logic [1:0]  req8;
  logic [15:0] addr8;
  logic [5:0]  len8;
  logic [1:0]  busy8, done8;
  logic [31:0] rdata8;
  logic        ram_rw8;
  logic [7:0]  ram_addr8, ram_wd8, ram_rd8;

  logic [7:0]  wmem [0:255];
  int          wcnt = 0;
  int          checks = 0;
  int          failures = 0;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(32)) u_dut (
    .clk_in(clk), .rst_in(rst), .req_in(req), .rw_in(rw), .addr_in(addr),
    .wdata_in(wdata), .len_in(len), .flush_in(flush), .busy_out(busy),
    .done_out(done), .rdata_out(rdata), .ram_rw_out(ram_rw),
    .ram_addr_out(ram_addr), .ram_data_out(ram_wd), .ram_data_in(ram_rd)
  );

  mem_arbiter #(.NUM_CH(2), .ADDR_W(8)) u_dut8 (
    .clk_in(clk), .rst_in(rst), .req_in(req8), .rw_in(2'b00), .addr_in(addr8),
    .wdata_in(64'h0), .len_in(len8), .flush_in(2'b00), .busy_out(busy8),
    .done_out(done8), .rdata_out(rdata8), .ram_rw_out(ram_rw8),
    .ram_addr_out(ram_addr8), .ram_data_out(ram_wd8), .ram_data_in(ram_rd8)
  );

  function automatic logic [7:0] rd_fn(input logic [7:0] a);
    case (a)
      8'h00:   rd_fn = 8'h11;
      8'h01:   rd_fn = 8'h22;
      8'h02:   rd_fn = 8'h33;
      8'h03:   rd_fn = 8'h44;
      8'hFE:   rd_fn = 8'hA1;
      8'hFF:   rd_fn = 8'hB2;
      default: rd_fn = 8'hEE;
    endcase
  endfunction

  always @(posedge clk) begin
    ram_rd <= rd_fn(ram_addr[7:0]);
    if (ram_rw) begin
      wmem[ram_addr[7:0]] <= ram_wd;
      wcnt <= wcnt + 1;
    end
  end

  always @(posedge clk) begin
    ram_rd8 <= rd_fn(ram_addr8);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int ch, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] l);
    req[ch]           = 1'b1;
    rw[ch]            = w;
    addr[ch*32 +: 32] = a;
    wdata[ch*32 +: 32] = d;
    len[ch*3 +: 3]    = l;
  endtask

  initial begin
    int w0;
    int f;
    int s;
    rst = 1'b1; req = 2'b00; rw = 2'b00; flush = 2'b00;
    addr = 64'h0; wdata = 64'h0; len = 6'h0;
    req8 = 2'b00; addr8 = 16'h0; len8 = 6'h0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 2'b00);
    check_val("rst_done", done, 2'b00);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_ramrw", ram_rw, 1'b0);
    check_val("rst_ramaddr", ram_addr, 32'h0);
    check_val("rst_ramdata", ram_wd, 8'h0);
    rst = 1'b0;

    // Two-byte write on channel 1.
    w0 = wcnt;
    issue(1, 1'b1, 32'h20, 32'hAABBCCDD, 3'd2);
    @(negedge clk);
    check_val("wr_busy", busy, 2'b10);
    check_val("wr_rw0", ram_rw, 1'b1);
    check_val("wr_addr0", ram_addr, 32'h20);
    check_val("wr_data0", ram_wd, 8'hDD);
    @(negedge clk);
    check_val("wr_rw1", ram_rw, 1'b1);
    check_val("wr_addr1", ram_addr, 32'h21);
    check_val("wr_data1", ram_wd, 8'hCC);
    @(negedge clk);
    check_val("wr_done", done, 2'b10);
    check_val("wr_busy_clr", busy, 2'b00);
    check_val("wr_rw_off", ram_rw, 1'b0);
    req[1] = 1'b0;
    @(negedge clk);
    check_val("wr_done_pulse", done, 2'b00);
    check_val("wr_count", wcnt - w0, 2);
    check_val("wr_mem", {wmem[8'h21], wmem[8'h20]}, 16'hCCDD);

    // Four-byte read on channel 0.
    issue(0, 1'b0, 32'h100, 32'h0, 3'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("rd_addr", ram_addr, 32'h100 + k);
      check_val("rd_rw", ram_rw, 1'b0);
      check_val("rd_busy", busy, 2'b01);
      check_val("rd_nodone", done, 2'b00);
    end
    @(negedge clk);
    check_val("rd_addr_hold", ram_addr, 32'h103);
    check_val("rd_busy_last", busy, 2'b01);
    @(negedge clk);
    check_val("rd_done", done, 2'b01);
    check_val("rd_data", rdata, 32'h44332211);
    check_val("rd_busy_clr", busy, 2'b00);
    req[0] = 1'b0;
    @(negedge clk);
    check_val("rd_done_pulse", done, 2'b00);
    check_val("rd_data_hold", rdata, 32'h44332211);

    // Simultaneous single-byte writes; last grant was channel 0.
`ifdef MEMARB_RR_EN
    f = 1;
`else
    f = 0;
`endif
    s = 1 - f;
    issue(0, 1'b1, 32'h40, 32'hA1, 3'd1);
    issue(1, 1'b1, 32'h41, 32'hB2, 3'd1);
    @(negedge clk);
    check_val("arb_busy_first", busy, 2'b01 << f);
    check_val("arb_addr_first", ram_addr, 32'h40 + f);
    check_val("arb_data_first", ram_wd, (f == 1) ? 8'hB2 : 8'hA1);
    @(negedge clk);
    check_val("arb_done_first", done, 2'b01 << f);
    req[f] = 1'b0;
    @(negedge clk);
    check_val("arb_busy_second", busy, 2'b01 << s);
    check_val("arb_addr_second", ram_addr, 32'h40 + s);
    @(negedge clk);
    check_val("arb_done_second", done, 2'b01 << s);
    req[s] = 1'b0;
    @(negedge clk);

    // Flush of a read at cnt=2.
    issue(0, 1'b0, 32'h100, 32'h0, 3'd4);
    repeat (3) @(negedge clk);
    check_val("fl_rd_busy", busy, 2'b01);
    flush[0] = 1'b1;
    @(negedge clk);
    check_val("fl_rd_busy_clr", busy, 2'b00);
    check_val("fl_rd_nodone", done, 2'b00);
    check_val("fl_rd_rdata", rdata, 32'h44332211);
    check_val("fl_rd_addr", ram_addr, 32'h0);
    req[0] = 1'b0;
    flush[0] = 1'b0;
    @(negedge clk);
    check_val("fl_rd_nodone2", done, 2'b00);

    // Flush during a write is ignored.
    w0 = wcnt;
    issue(0, 1'b1, 32'h50, 32'h04030201, 3'd4);
    @(negedge clk);
    check_val("fl_wr_busy", busy, 2'b01);
    @(negedge clk);
    flush[0] = 1'b1;
    repeat (2) @(negedge clk);
    check_val("fl_wr_busy_last", busy, 2'b01);
    check_val("fl_wr_addr_last", ram_addr, 32'h53);
    check_val("fl_wr_data_last", ram_wd, 8'h04);
    @(negedge clk);
    check_val("fl_wr_done", done, 2'b01);
    check_val("fl_wr_busy_clr", busy, 2'b00);
    req[0] = 1'b0;
    flush[0] = 1'b0;
    @(negedge clk);
    check_val("fl_wr_count", wcnt - w0, 4);
    check_val("fl_wr_mem", {wmem[8'h53], wmem[8'h52], wmem[8'h51], wmem[8'h50]}, 32'h04030201);

    // Reset in the middle of a write, then a normal read.
    issue(1, 1'b1, 32'h60, 32'h11111111, 3'd4);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("mrst_busy", busy, 2'b00);
    check_val("mrst_done", done, 2'b00);
    check_val("mrst_rw", ram_rw, 1'b0);
    check_val("mrst_addr", ram_addr, 32'h0);
    check_val("mrst_data", ram_wd, 8'h0);
    check_val("mrst_rdata", rdata, 32'h0);
    rst = 1'b0;
    req[1] = 1'b0;
    issue(0, 1'b0, 32'h102, 32'h0, 3'd2);
    @(negedge clk);
    check_val("post_addr0", ram_addr, 32'h102);
    @(negedge clk);
    check_val("post_addr1", ram_addr, 32'h103);
    @(negedge clk);
    check_val("post_hold", ram_addr, 32'h103);
    check_val("post_busy", busy, 2'b01);
    @(negedge clk);
    check_val("post_done", done, 2'b01);
    check_val("post_rdata", rdata, 32'h00004433);
    req[0] = 1'b0;
    @(negedge clk);

    // Address wrap with an 8-bit address.
    req8[0] = 1'b1;
    addr8[7:0] = 8'hFE;
    len8[2:0] = 3'd4;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ea;
      ea = 8'hFE + 8'(k);
      @(negedge clk);
      check_val("wrap_addr", ram_addr8, ea);
    end
    @(negedge clk);
    check_val("wrap_hold", ram_addr8, 8'h01);
    @(negedge clk);
    check_val("wrap_done", done8, 2'b01);
    check_val("wrap_rdata", rdata8, 32'h2211B2A1);
    req8[0] = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
